// File: rtl/sprite_renderer.sv
// sprite_renderer
//
// Pixel-side sprite compositor. For each pixel from the VGA timing generator
// it decides which sprite (if any) covers the pixel and produces its colour.
// Sprite rectangles are copied into shadow registers only on new_frame_i, so
// game logic can move sprites at any time without tearing the picture.
// The pipeline is two registered stages; the sync and visible signals are
// delayed by the same two cycles so they stay aligned with rgb_o.
//
// Ports:
//   clk_i            pixel clock
//   rst_i            synchronous active-high reset
//   x_i, y_i         current pixel column / row
//   visible_i        pixel lies in the active area
//   hsync_i, vsync_i active-low syncs from the timing generator
//   new_frame_i      one-cycle pulse at the start of vertical blanking
//   spr_x_pos_i      per-sprite left edge (inclusive)
//   spr_y_pos_i      per-sprite top edge (inclusive)
//   spr_right_i      per-sprite right edge (exclusive)
//   spr_bottom_i     per-sprite bottom edge (exclusive)
//   rgb_o            pixel colour, valid two cycles after the pixel input
//   hsync_o, vsync_o, visible_o  inputs delayed by two cycles

module sprite_renderer #(
    parameter int N_SPRITES    = 3,
    parameter int COLOR_W      = 12,
    parameter int X_POS_W      = 10,
    parameter int Y_POS_W      = 10,
    parameter int SCREEN_H_RES = 640,
    parameter logic [N_SPRITES-1:0][COLOR_W-1:0] SPRITE_COLORS = {12'hFFF, 12'hF00, 12'h0F0},
    parameter logic [COLOR_W-1:0] NET_COLOR = 12'h888,
    parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h000,
    parameter int NET_X        = SCREEN_H_RES / 2 - 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [X_POS_W-1:0]                x_i,
    input  logic [Y_POS_W-1:0]                y_i,
    input  logic                              visible_i,
    input  logic                              hsync_i,
    input  logic                              vsync_i,
    input  logic                              new_frame_i,
    input  logic [N_SPRITES-1:0][X_POS_W-1:0] spr_x_pos_i,
    input  logic [N_SPRITES-1:0][Y_POS_W-1:0] spr_y_pos_i,
    input  logic [N_SPRITES-1:0][X_POS_W-1:0] spr_right_i,
    input  logic [N_SPRITES-1:0][Y_POS_W-1:0] spr_bottom_i,
    output logic [COLOR_W-1:0]                rgb_o,
    output logic                              hsync_o,
    output logic                              vsync_o,
    output logic                              visible_o
);

    localparam logic [X_POS_W-1:0] NET_X_LO = X_POS_W'(NET_X);
    localparam logic [X_POS_W-1:0] NET_X_HI = X_POS_W'(NET_X + 1);

    // Shadow copy of the sprite rectangles used for the whole frame
    logic [N_SPRITES-1:0][X_POS_W-1:0] shadow_x_pos_q,  shadow_x_pos_d;
    logic [N_SPRITES-1:0][Y_POS_W-1:0] shadow_y_pos_q,  shadow_y_pos_d;
    logic [N_SPRITES-1:0][X_POS_W-1:0] shadow_right_q,  shadow_right_d;
    logic [N_SPRITES-1:0][Y_POS_W-1:0] shadow_bottom_q, shadow_bottom_d;

    // Stage 1: per-sprite hit bits, net bit and delayed timing signals
    logic [N_SPRITES-1:0] hit_q,      hit_d;
    logic                 net_q,      net_d;
    logic                 visible1_q, visible1_d;
    logic                 hsync1_q,   hsync1_d;
    logic                 vsync1_q,   vsync1_d;

    // Stage 2: registered outputs
    logic [COLOR_W-1:0]   rgb_q,      rgb_d;
    logic                 hsync2_q,   hsync2_d;
    logic                 vsync2_q,   vsync2_d;
    logic                 visible2_q, visible2_d;

    // Shadow load: the stage-1 comparison below reads the _q values, so a
    // pixel presented together with new_frame_i still sees the old frame.
    always_comb begin
        shadow_x_pos_d  = shadow_x_pos_q;
        shadow_y_pos_d  = shadow_y_pos_q;
        shadow_right_d  = shadow_right_q;
        shadow_bottom_d = shadow_bottom_q;
        if (new_frame_i) begin
            shadow_x_pos_d  = spr_x_pos_i;
            shadow_y_pos_d  = spr_y_pos_i;
            shadow_right_d  = spr_right_i;
            shadow_bottom_d = spr_bottom_i;
        end
    end

    // Stage 1: rectangle test with exclusive right/bottom edges. A rectangle
    // whose right/bottom is not beyond its x/y position can never satisfy
    // both halves of a test, so empty sprites need no special case.
    always_comb begin
        hit_d = '0;
        for (int k = 0; k < N_SPRITES; k++) begin
            hit_d[k] = (shadow_x_pos_q[k] <= x_i) && (x_i < shadow_right_q[k]) &&
                       (shadow_y_pos_q[k] <= y_i) && (y_i < shadow_bottom_q[k]);
        end
        // Dashed centre net: 2 pixels wide, 8 rows on / 8 rows off
        net_d      = ((x_i == NET_X_LO) || (x_i == NET_X_HI)) && !y_i[3];
        visible1_d = visible_i;
        hsync1_d   = hsync_i;
        vsync1_d   = vsync_i;
    end

    // Stage 2: colour priority. The loop runs from the highest index down so
    // the lowest-index hit is assigned last and wins; sprites override the
    // net, and blanking overrides everything.
    always_comb begin
        rgb_d = net_q ? NET_COLOR : BG_COLOR;
        for (int k = N_SPRITES - 1; k >= 0; k--) begin
            if (hit_q[k]) begin
                rgb_d = SPRITE_COLORS[k];
            end
        end
        if (!visible1_q) begin
            rgb_d = '0;
        end
        hsync2_d   = hsync1_q;
        vsync2_d   = vsync1_q;
        visible2_d = visible1_q;
    end

    // All state registers; reset puts the syncs in their inactive (high)
    // level and blanks the picture in both stages.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_x_pos_q  <= '0;
            shadow_y_pos_q  <= '0;
            shadow_right_q  <= '0;
            shadow_bottom_q <= '0;
            hit_q           <= '0;
            net_q           <= 1'b0;
            visible1_q      <= 1'b0;
            hsync1_q        <= 1'b1;
            vsync1_q        <= 1'b1;
            rgb_q           <= '0;
            hsync2_q        <= 1'b1;
            vsync2_q        <= 1'b1;
            visible2_q      <= 1'b0;
        end else begin
            shadow_x_pos_q  <= shadow_x_pos_d;
            shadow_y_pos_q  <= shadow_y_pos_d;
            shadow_right_q  <= shadow_right_d;
            shadow_bottom_q <= shadow_bottom_d;
            hit_q           <= hit_d;
            net_q           <= net_d;
            visible1_q      <= visible1_d;
            hsync1_q        <= hsync1_d;
            vsync1_q        <= vsync1_d;
            rgb_q           <= rgb_d;
            hsync2_q        <= hsync2_d;
            vsync2_q        <= vsync2_d;
            visible2_q      <= visible2_d;
        end
    end

    assign rgb_o     = rgb_q;
    assign hsync_o   = hsync2_q;
    assign vsync_o   = vsync2_q;
    assign visible_o = visible2_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer
//
// Bench for sprite_renderer. A frame-level reference model predicts every
// output from rectangle containment, priority and a two-cycle delay; a
// compare process checks it each cycle. Directed scenarios additionally
// carry hand-computed literal colours, then a long randomized run follows.

module tb_sprite_renderer;

    localparam int N  = 3;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam logic [11:0] COL0 = 12'h0F0;
    localparam logic [11:0] COL1 = 12'hF00;
    localparam logic [11:0] COL2 = 12'hFFF;
    localparam logic [11:0] NETC = 12'h888;
    localparam logic [11:0] BGC  = 12'h000;
    localparam int NET_COL = 319;

    logic                      clk = 1'b0;
    logic                      rst_i = 1'b1;
    logic [XW-1:0]             x_i = '0;
    logic [YW-1:0]             y_i = '0;
    logic                      visible_i = 1'b0;
    logic                      hsync_i = 1'b1;
    logic                      vsync_i = 1'b1;
    logic                      new_frame_i = 1'b0;
    logic [N-1:0][XW-1:0]      spr_x_pos_i = '0;
    logic [N-1:0][YW-1:0]      spr_y_pos_i = '0;
    logic [N-1:0][XW-1:0]      spr_right_i = '0;
    logic [N-1:0][YW-1:0]      spr_bottom_i = '0;
    logic [11:0]               rgb_o;
    logic                      hsync_o;
    logic                      vsync_o;
    logic                      visible_o;

    int errors = 0;
    int checks = 0;

    sprite_renderer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .x_i          (x_i),
        .y_i          (y_i),
        .visible_i    (visible_i),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .new_frame_i  (new_frame_i),
        .spr_x_pos_i  (spr_x_pos_i),
        .spr_y_pos_i  (spr_y_pos_i),
        .spr_right_i  (spr_right_i),
        .spr_bottom_i (spr_bottom_i),
        .rgb_o        (rgb_o),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .visible_o    (visible_o)
    );

    always #5 clk = ~clk;

    // Single comparison point used by every check in the bench
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        vis;
    } out_t;

    localparam out_t RESET_OUT = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, vis: 1'b0};

    int   m_x0[N];
    int   m_y0[N];
    int   m_x1[N];
    int   m_y1[N];
    out_t m_stage = RESET_OUT;
    out_t m_out   = RESET_OUT;
    bit   m_armed = 1'b0;

    // Colour a pixel from the frame's rectangles: first covering sprite wins,
    // then the dashed net, then background; blanked pixels are black.
    function automatic logic [11:0] model_colour(input int x, input int y, input bit vis);
        logic [11:0] c;
        if (!vis) return 12'h000;
        for (int k = 0; k < N; k++) begin
            if (x >= m_x0[k] && x < m_x1[k] && y >= m_y0[k] && y < m_y1[k]) begin
                c = (k == 0) ? COL0 : (k == 1) ? COL1 : COL2;
                return c;
            end
        end
        if ((x == NET_COL || x == NET_COL + 1) && ((y / 8) % 2 == 0)) return NETC;
        return BGC;
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            m_out   = RESET_OUT;
            m_stage = RESET_OUT;
            for (int k = 0; k < N; k++) begin
                m_x0[k] = 0; m_y0[k] = 0; m_x1[k] = 0; m_y1[k] = 0;
            end
            m_armed = 1'b1;
        end else begin
            m_out   = m_stage;
            m_stage = '{rgb: model_colour(int'(x_i), int'(y_i), visible_i),
                        hs: hsync_i, vs: vsync_i, vis: visible_i};
            if (new_frame_i) begin
                for (int k = 0; k < N; k++) begin
                    m_x0[k] = int'(spr_x_pos_i[k]);
                    m_y0[k] = int'(spr_y_pos_i[k]);
                    m_x1[k] = int'(spr_right_i[k]);
                    m_y1[k] = int'(spr_bottom_i[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            checkOutput("model_rgb",     32'(rgb_o),     32'(m_out.rgb));
            checkOutput("model_hsync",   32'(hsync_o),   32'(m_out.hs));
            checkOutput("model_vsync",   32'(vsync_o),   32'(m_out.vs));
            checkOutput("model_visible", 32'(visible_o), 32'(m_out.vis));
        end
    end

    // ---------------- stimulus ----------------
    bit          lit_en[2];
    logic [11:0] lit_val[2];
    string       lit_name[2];

    task automatic setSprite(input int k, input int x0, input int y0, input int x1, input int y1);
        spr_x_pos_i[k]  = XW'(x0);
        spr_y_pos_i[k]  = YW'(y0);
        spr_right_i[k]  = XW'(x1);
        spr_bottom_i[k] = YW'(y1);
    endtask

    // One pixel cycle. A literal colour attached to this pixel is checked
    // two calls later, i.e. after exactly two rising edges.
    task automatic applyStimulus(input int x, input int y, input bit vis, input bit nf,
                                 input bit rst, input bit hs, input bit vs,
                                 input bit lit, input logic [11:0] lv, input string nm);
        @(negedge clk);
        if (lit_en[1]) checkOutput(lit_name[1], 32'(rgb_o), 32'(lit_val[1]));
        lit_en[1]   = lit_en[0];
        lit_val[1]  = lit_val[0];
        lit_name[1] = lit_name[0];
        lit_en[0]   = lit;
        lit_val[0]  = lv;
        lit_name[0] = nm;
        x_i         = XW'(x);
        y_i         = YW'(y);
        visible_i   = vis;
        new_frame_i = nf;
        rst_i       = rst;
        hsync_i     = hs;
        vsync_i     = vs;
    endtask

    task automatic pix(input int x, input int y, input logic [11:0] lv, input string nm);
        applyStimulus(x, y, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, lv, nm);
    endtask

    task automatic idle(input bit nf);
        applyStimulus(0, 479, 1'b1, nf, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "");
    endtask

    initial begin
        lit_en[0] = 1'b0;
        lit_en[1] = 1'b0;

        // Reset held with syncs low and visible high
        for (int i = 0; i < 3; i++)
            applyStimulus(10, 10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "");
        @(posedge clk); #1;
        checkOutput("reset_rgb",     32'(rgb_o),     32'h0);
        checkOutput("reset_hsync",   32'(hsync_o),   32'h1);
        checkOutput("reset_vsync",   32'(vsync_o),   32'h1);
        checkOutput("reset_visible", 32'(visible_o), 32'h0);
        pix(10, 10, BGC, "post_reset_bg");
        idle(1'b0);

        // Edges and latency on sprite 2
        setSprite(2, 100, 50, 108, 58);
        idle(1'b1);
        pix(99,  50, BGC,  "edge_x99");
        pix(100, 50, COL2, "edge_x100");
        pix(107, 50, COL2, "edge_x107");
        pix(108, 50, BGC,  "edge_x108");
        pix(100, 58, BGC,  "edge_row58");
        pix(107, 57, COL2, "edge_row57");
        idle(1'b0);

        // Priority and net
        setSprite(0, 290, 190, 310, 210);
        setSprite(2, 280, 0, 330, 220);
        idle(1'b1);
        pix(300, 200, COL0, "prio_overlap");
        pix(319, 8,   COL2, "prio_over_net");
        pix(295, 5,   COL2, "prio_sprite2_only");
        setSprite(0, 0, 0, 0, 0);
        setSprite(2, 0, 0, 0, 0);
        idle(1'b1);
        pix(319, 8, BGC,  "net_gap");
        pix(319, 0, NETC, "net_on");
        pix(320, 7, NETC, "net_right_col");
        pix(321, 0, BGC,  "net_beside");
        idle(1'b0);

        // Blanking over a sprite
        setSprite(2, 100, 50, 108, 58);
        idle(1'b1);
        applyStimulus(100, 50, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, "blank_over_sprite");
        pix(100, 50, COL2, "unblank_sprite");

        // Tear-free latch
        setSprite(2, 200, 50, 208, 58);
        pix(100, 50, COL2, "tear_hold_old");
        pix(200, 50, BGC,  "tear_new_ignored");
        applyStimulus(100, 50, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, COL2, "tear_same_cycle");
        pix(200, 50, COL2, "tear_next_new");
        pix(100, 50, BGC,  "tear_old_gone");
        idle(1'b0);

        // Mid-frame reset while a sprite is hit
        setSprite(2, 100, 50, 108, 58);
        idle(1'b1);
        applyStimulus(100, 50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, COL2, "midrst_before");
        applyStimulus(101, 50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "");
        applyStimulus(102, 50, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, "midrst_stage_cleared");
        @(posedge clk); #1;
        checkOutput("midrst_rgb",     32'(rgb_o),     32'h0);
        checkOutput("midrst_hsync",   32'(hsync_o),   32'h1);
        checkOutput("midrst_visible", 32'(visible_o), 32'h0);
        pix(100, 50, BGC, "midrst_shadow_cleared");
        pix(104, 55, BGC, "midrst_shadow_cleared2");
        idle(1'b1);
        pix(100, 50, COL2, "midrst_reloaded");
        idle(1'b0);
        idle(1'b0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                int k;
                int x0;
                int y0;
                k  = int'($urandom_range(N - 1, 0));
                x0 = int'($urandom_range(340, 80));
                y0 = int'($urandom_range(220, 0));
                setSprite(k, x0, y0,
                          x0 + int'($urandom_range(45, 0)) - 5,
                          y0 + int'($urandom_range(45, 0)) - 5);
            end
            applyStimulus(int'($urandom_range(340, 80)), int'($urandom_range(240, 0)),
                          ($urandom_range(7, 0) != 0),
                          ($urandom_range(15, 0) == 0),
                          ($urandom_range(255, 0) == 0),
                          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                          1'b0, 12'h000, "");
        end
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
